// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - serial shift sequencing controller (load, shift, parity, gap)
//
// Purpose: accepts a parallel word over a valid/ready handshake, sends it out
// LSB first one bit per clock with a framing strobe, optionally appends an
// even-parity bit, then holds off for GAP idle cycles before the next word.
//
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset
//   data_i   : parallel word, sampled only on accept (valid_i & ready_o)
//   valid_i  : producer has a word on data_i
//   ready_o  : controller can accept a word (IDLE and not in reset)
//   sd_o     : serial data, 0 whenever frame_o is 0
//   frame_o  : high while sd_o carries a frame bit
//   busy_o   : high in every state except IDLE
//   done_o   : one-cycle pulse in the cycle after the last frame bit
//
// Configuration macro: SHIFT_SEQ_CTRL_PARITY_EN
//   defined   : PAR state compiled in, frames are WIDTH+1 bits (even parity last)
//   undefined : frames are exactly WIDTH bits
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             sd_o,
  output logic             frame_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Where the controller goes once the final frame bit has been sent; with no
  // gap the done cycle is already an IDLE cycle.
  localparam state_t POST_FRAME = (GAP > 0) ? ST_GAP : ST_IDLE;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             sd_q, sd_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  logic             par_q, par_d;
`endif

  // Serial outputs are computed for the *next* state so they come straight
  // from flops; sd_d therefore looks one bit ahead in the shift register.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sd_d      = 1'b0;
    frame_d   = 1'b0;
    done_d    = 1'b0;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          state_d   = ST_SHIFT;
          shreg_d   = data_i;
          bit_cnt_d = '0;
          sd_d      = data_i[0];
          frame_d   = 1'b1;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
          par_d     = ^data_i;
`endif
        end
      end
      ST_SHIFT: begin
        shreg_d   = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q != BIT_LAST) begin
          sd_d    = shreg_q[1];
          frame_d = 1'b1;
        end else begin
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
          state_d = ST_PAR;
          sd_d    = par_q;
          frame_d = 1'b1;
`else
          state_d   = POST_FRAME;
          gap_cnt_d = '0;
          done_d    = 1'b1;
`endif
        end
      end
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
      ST_PAR: begin
        state_d   = POST_FRAME;
        gap_cnt_d = '0;
        done_d    = 1'b1;
      end
`endif
      ST_GAP: begin
        // The done cycle is the first gap cycle, so GAP cycles in total.
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sd_q      <= 1'b0;
      frame_q   <= 1'b0;
      done_q    <= 1'b0;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sd_q      <= sd_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // Reset blocks acceptance immediately so rst_i wins over valid_i.
  assign ready_o = (state_q == ST_IDLE) && !rst_i;
  assign busy_o  = (state_q != ST_IDLE);
  assign sd_o    = sd_q;
  assign frame_o = frame_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - randomized self-checking bench for shift_seq_ctrl (GAP=2 and GAP=0)
module tb_shift_seq_ctrl;

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int W     = 8;
  localparam int FL    = W + PAR;
  localparam int DEPTH = 8192;
  localparam int GAPS [2] = '{2, 0};

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       valid_i = 1'b0;
  logic [7:0] data_i = 8'h00;

  logic ready_a, sd_a, frame_a, busy_a, done_a;
  logic ready_b, sd_b, frame_b, busy_b, done_b;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(8), .GAP(2)) u_dut_g2 (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_a), .sd_o(sd_a), .frame_o(frame_a), .busy_o(busy_a), .done_o(done_a)
  );

  shift_seq_ctrl #(.WIDTH(8), .GAP(0)) u_dut_g0 (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_b), .sd_o(sd_b), .frame_o(frame_b), .busy_o(busy_b), .done_o(done_b)
  );

  // Timeline model: cycle j is the clock period following edge j. An accept
  // at edge c books bits into cycles c..c+W-1, parity at c+W, done right after
  // the last frame bit, and the controller is idle again GAP cycles later.
  bit e_sd [2][DEPTH];
  bit e_fr [2][DEPTH];
  bit e_dn [2][DEPTH];
  int free_at [2];
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic tick(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk);
    rst_i = r; valid_i = v; data_i = d;
    @(posedge clk);
    cyc++;
    for (int g = 0; g < 2; g++) begin
      if (r) begin
        for (int j = cyc; j < cyc + 32; j++) begin
          e_sd[g][j] = 1'b0; e_fr[g][j] = 1'b0; e_dn[g][j] = 1'b0;
        end
        free_at[g] = cyc;
      end else if (v && (cyc - 1 >= free_at[g])) begin
        for (int k = 0; k < W; k++) begin
          e_sd[g][cyc + k] = d[k];
          e_fr[g][cyc + k] = 1'b1;
        end
        if (PAR == 1) begin
          e_sd[g][cyc + W] = ^d;
          e_fr[g][cyc + W] = 1'b1;
        end
        e_dn[g][cyc + FL] = 1'b1;
        free_at[g] = cyc + FL + GAPS[g];
      end
    end
    #1;
  endtask

  // {ready, busy, frame, sd, done}
  function automatic logic [4:0] exp_vec(input int g);
    return {(!rst_i && (cyc >= free_at[g])), (cyc < free_at[g]),
            e_fr[g][cyc], e_sd[g][cyc], e_dn[g][cyc]};
  endfunction

  function automatic logic [4:0] obs_vec(input int g);
    if (g == 0) return {ready_a, busy_a, frame_a, sd_a, done_a};
    return {ready_b, busy_b, frame_b, sd_b, done_b};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      tick(i < 3, 1'b0, 8'($urandom));
      for (int g = 0; g < 2; g++) begin
        n_cmp++;
        if (obs_vec(g) !== exp_vec(g)) begin
          n_err++;
          $display("FAIL reset dut%0d cycle %0d: got %b required %b", g, cyc, obs_vec(g), exp_vec(g));
        end
      end
    end
  endtask

  task automatic test_single_a5();
    logic [15:0] fb = '0;
    int nf = 0;
    int done_at = -1;
    int acc = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, i == 0, (i == 0) ? 8'hA5 : 8'($urandom));
      if (i == 0) acc = cyc;
      if (frame_a && nf < 16) begin fb[nf] = sd_a; nf++; end
      if (done_a) done_at = cyc - acc;
      for (int g = 0; g < 2; g++) begin
        n_cmp++;
        if (obs_vec(g) !== exp_vec(g)) begin
          n_err++;
          $display("FAIL single_a5 dut%0d cycle %0d: got %b required %b", g, cyc, obs_vec(g), exp_vec(g));
        end
      end
    end
    n_cmp++;
    if (fb[7:0] !== 8'hA5 || nf != FL) begin
      n_err++;
      $display("FAIL a5_bits: got %h (%0d bits) required a5 (%0d bits)", fb[7:0], nf, FL);
    end
    n_cmp++;
    if (done_at != FL) begin
      n_err++;
      $display("FAIL a5_done_offset: got %0d required %0d", done_at, FL);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 48; i++) begin
      tick(1'b0, i < 30, (i == 0) ? 8'h3C : 8'hFF);
      for (int g = 0; g < 2; g++) begin
        n_cmp++;
        if (obs_vec(g) !== exp_vec(g)) begin
          n_err++;
          $display("FAIL back_to_back dut%0d cycle %0d: got %b required %b", g, cyc, obs_vec(g), exp_vec(g));
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 16; i++) begin
      tick(i == 4, (i == 0) || (i == 4), 8'hA5);
      for (int g = 0; g < 2; g++) begin
        n_cmp++;
        if (obs_vec(g) !== exp_vec(g)) begin
          n_err++;
          $display("FAIL reset_mid_frame dut%0d cycle %0d: got %b required %b", g, cyc, obs_vec(g), exp_vec(g));
        end
      end
    end
  endtask

  task automatic test_ignore_valid();
    for (int i = 0; i < 14; i++) begin
      tick(1'b0, (i == 0) ? 1'b1 : ((i < FL) ? 1'($urandom) : 1'b0), (i == 0) ? 8'hA5 : 8'h00);
      for (int g = 0; g < 2; g++) begin
        n_cmp++;
        if (obs_vec(g) !== exp_vec(g)) begin
          n_err++;
          $display("FAIL ignore_valid dut%0d cycle %0d: got %b required %b", g, cyc, obs_vec(g), exp_vec(g));
        end
      end
    end
  endtask

  task automatic test_parity_bits();
    logic [7:0] words [2] = '{8'hA5, 8'h07};
    for (int w = 0; w < 2; w++) begin
      logic par_seen = 1'b0;
      int nf = 0;
      for (int i = 0; i < 14; i++) begin
        tick(1'b0, i == 0, words[w]);
        if (frame_a) begin
          nf++;
          if (nf == FL) par_seen = sd_a;
        end
      end
      n_cmp++;
      if (PAR == 1 && par_seen !== ^words[w]) begin
        n_err++;
        $display("FAIL parity_bit word %h: got %b required %b", words[w], par_seen, ^words[w]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 900; i++) begin
      tick(($urandom % 100) == 0, 1'($urandom), 8'($urandom));
      for (int g = 0; g < 2; g++) begin
        n_cmp++;
        if (obs_vec(g) !== exp_vec(g)) begin
          n_err++;
          $display("FAIL random dut%0d cycle %0d: got %b required %b", g, cyc, obs_vec(g), exp_vec(g));
        end
      end
    end
  endtask

  initial begin
    free_at[0] = 0;
    free_at[1] = 0;
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_reset_mid_frame();
    test_ignore_valid();
    test_parity_bits();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencing controller for the serial shift datapath. It accepts a parallel word through a valid/ready handshake and drives it out one bit per clock, LSB first, with a framing strobe. It then enforces a programmable idle gap before accepting the next word. It sits between a word-oriented producer and any serial shift chain downstream, and owns all timing of load, shift and frame boundaries.

## Interface
Parameters:
- WIDTH, default 8: bits per word; legal range 2..32.
- GAP, default 2: idle cycles enforced after each frame's done cycle; legal range 0..15.

Ports:
- clk_i  input  1  clock; all logic is on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- data_i  input  WIDTH  parallel word; sampled only on an accept edge.
- valid_i  input  1  producer has a word on data_i.
- ready_o  output  1  controller can accept a word; accept = valid_i & ready_o at a rising edge.
- sd_o  output  1  serial data; 0 whenever frame_o is 0.
- frame_o  output  1  high exactly while sd_o carries a frame bit.
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  one-cycle pulse in the cycle after the last frame bit.

## Operation
- States: IDLE, SHIFT, PAR (parity build only), GAP.
- IDLE:
  - ready_o=1, busy_o=0, frame_o=0, sd_o=0.
  - On accept, load data_i into the internal shift register, clear the bit counter, and go to SHIFT.
  - With no accept, stay in IDLE.
- SHIFT:
  - sd_o = shift register bit 0; frame_o=1; ready_o=0.
  - Each cycle, shift right one bit and increment the bit counter.
  - After WIDTH bits, go to PAR if parity is compiled in; otherwise go to GAP if GAP>0, else IDLE.
- PAR: for one cycle, sd_o = even-parity bit of the accepted word and frame_o=1; then go to GAP if GAP>0, else IDLE.
- GAP:
  - ready_o=0, frame_o=0, sd_o=0.
  - A gap counter runs GAP cycles, then the controller returns to IDLE.
- done_o:
  - Asserts for one cycle on the first cycle after the final frame bit, i.e. the first GAP cycle, or the first IDLE cycle when GAP=0.
  - Never asserts outside that cycle.
- Width rules:
  - Bit counter is $clog2(WIDTH+1) bits; gap counter is $clog2(GAP+1) bits, minimum 1.
  - Neither counter may wrap during normal operation.
- Boundary conditions:
  - valid_i while ready_o=0: ignored; no state change; data_i not sampled.
  - data_i changing after accept: no effect on the frame in flight.
  - GAP=0: the done cycle is an IDLE cycle with ready_o=1, so an accept there gives back-to-back frames separated by exactly one idle cycle.
  - rst_i asserted mid-frame: at the next edge the state is IDLE, the frame is discarded, and no done_o pulse is issued.
  - rst_i and valid_i high together: reset wins; nothing is accepted.

## Timing
- Reset values (at the edge where rst_i is sampled high): state IDLE, sd_o=0, frame_o=0, busy_o=0, done_o=0, counters 0.
- ready_o is 0 while rst_i is high and 1 in the first cycle after release.
- Let accept occur at edge N:
  - Bit k appears on sd_o during cycle N+1+k, for k=0..WIDTH-1.
  - With parity, the parity bit appears during cycle N+WIDTH+1.
  - done_o fires during cycle N+WIDTH+1 (non-parity) or N+WIDTH+2 (parity build).
  - ready_o returns high GAP cycles after the done cycle.
- Outputs sd_o, frame_o and done_o are registered or decoded from registered state only; there is no combinational path from valid_i or data_i to any output.
- ready_o is decoded from state and rst_i only.

## Configuration
- Macro: SHIFT_SEQ_CTRL_PARITY_EN.
- Defined: the PAR state is compiled in; each frame is WIDTH+1 bits with an even-parity bit last, giving a total count of ones that is even.
- Undefined: no PAR state; each frame is exactly WIDTH bits; all latencies are as listed for the non-parity build.

## Test plan
All scenarios use WIDTH=8, GAP=2 unless stated.
- Reset release, valid_i=0: ready_o=1, busy_o=0, frame_o=0, sd_o=0, done_o=0 every cycle.
- Accept 0xA5 at edge N:
  - sd_o = 1,0,1,0,0,1,0,1 in cycles N+1..N+8, with frame_o=1 throughout.
  - done_o=1 in cycle N+9 only; ready_o=0 in N+9..N+10 and 1 in N+11.
- Hold valid_i=1 with 0x3C then 0xFF, GAP=0: the second accept occurs in the done cycle, so the frames are separated by exactly one frame_o=0 cycle; 0xFF gives eight 1s; 0x3C is unaffected.
- Assert rst_i during cycle N+4 of a 0xA5 frame: from the next cycle frame_o=0, sd_o=0, no done_o pulse, and ready_o=1 after rst_i falls.
- Pulse valid_i with data_i=0x00 during frame and GAP cycles: no accept and no change to the sd_o sequence of the frame in flight.
- With SHIFT_SEQ_CTRL_PARITY_EN defined:
  - 0xA5 gives parity bit 0 in cycle N+9 and done_o in N+10.
  - 0x07 gives parity bit 1.
